// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_pkg
// Description : Shared PIO definitions: sequencer state encoding, default
//               divider/delay widths and the instruction delay/side-set
//               field layout used by both sequencer and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

  // Default widths for the fractional clock divider and delay counter.
  localparam int DEF_DIV_INT_W  = 16;
  localparam int DEF_DIV_FRAC_W = 8;
  localparam int DEF_DELAY_W    = 5;

  // The delay/side-set field occupies instruction bits [12:8]. Side-set bits
  // are taken from the MSB end; whatever remains below them is delay.
  localparam int INSTR_DS_LSB = 8;
  localparam int INSTR_DS_W   = 5;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    SM_IDLE  = 2'd0,
    SM_RUN   = 2'd1,
    SM_DELAY = 2'd2
  } sm_state_e;

  // Extract the delay portion of the delay/side-set field, given how many
  // of its bits are claimed by side-set (including the optional enable bit).
  function automatic logic [INSTR_DS_W-1:0] ds_delay(
    input logic [15:0] instr,
    input logic [2:0]  ss_bits
  );
    logic [INSTR_DS_W-1:0] field;
    logic [5:0]            mask;
    field = instr[INSTR_DS_LSB +: INSTR_DS_W];
    mask  = 6'd0;
    if (ss_bits < 3'd5) begin
      mask = (6'd1 << (3'd5 - ss_bits)) - 6'd1;
    end
    return field & mask[INSTR_DS_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pio_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : pio_clkdiv
// Description : Fractional clock divider. Adds one unit per enabled cycle
//               to an accumulator and emits a registered tick whenever the
//               accumulator reaches the divisor {div_int, div_frac}.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_clkdiv
  import pio_pkg::*;
#(
  parameter int DIV_INT_W  = DEF_DIV_INT_W,
  parameter int DIV_FRAC_W = DEF_DIV_FRAC_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  output logic                  penable
);

  // One extra bit so that acc + one unit never overflows even at the
  // largest divisor.
  localparam int ACC_W = DIV_INT_W + DIV_FRAC_W + 1;

  // One whole cycle expressed in fractional units.
  localparam logic [ACC_W-1:0] ONE_STEP =
    {{(ACC_W-1){1'b0}}, 1'b1} << DIV_FRAC_W;

  // Divisor used when the integer part is zero (2^(int+frac) units).
  localparam logic [ACC_W-1:0] DIV_MAX =
    {{(ACC_W-1){1'b0}}, 1'b1} << (DIV_INT_W + DIV_FRAC_W);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             penable_q, penable_d;
  logic [ACC_W-1:0] divisor;
  logic [ACC_W-1:0] sum;

  // Effective divisor; a zero integer part selects the maximum divisor,
  // which also keeps sub-unity values from ever being programmed.
  always_comb begin
    divisor = {1'b0, div_int, div_frac};
    if (div_int == '0) begin
      divisor = DIV_MAX;
    end
  end

  // Accumulate one unit per enabled cycle; tick when the sum reaches the
  // divisor and carry the remainder so the long-run rate is exact.
  always_comb begin
    sum       = acc_q + ONE_STEP;
    acc_d     = acc_q;
    penable_d = 1'b0;
    if (restart) begin
      acc_d = '0;
    end else if (en) begin
      if (sum >= divisor) begin
        acc_d     = sum - divisor;
        penable_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Accumulator and tick registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      penable_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      penable_q <= penable_d;
    end
  end

  assign penable = penable_q;

endmodule
`default_nettype wire

// File: rtl/pio_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pio_sm_sequencer
// Description : Per-state-machine execution sequencer. Generates the divided
//               execute tick, tracks instruction delay cycles and stalls,
//               and grants forced (EXEC) instruction injection. Drives the
//               program counter's penable, stalled and imm inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_sm_sequencer
  import pio_pkg::*;
#(
  parameter int DIV_INT_W  = DEF_DIV_INT_W,
  parameter int DIV_FRAC_W = DEF_DIV_FRAC_W,
  parameter int DELAY_W    = DEF_DELAY_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic                  instr_stall,
  input  logic [DELAY_W-1:0]    delay,
  input  logic                  exec_req,
  output logic                  exec_ack,
  output logic                  penable,
  output logic                  stalled,
  output logic                  imm,
  output logic                  delay_active
);

  localparam logic [DELAY_W-1:0] DCNT_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

  sm_state_e          state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic               tick;
  logic               grant;
  logic               completion;

  pio_clkdiv #(
    .DIV_INT_W  (DIV_INT_W),
    .DIV_FRAC_W (DIV_FRAC_W)
  ) u_clkdiv (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .restart  (restart),
    .div_int  (div_int),
    .div_frac (div_frac),
    .penable  (tick)
  );

  // A forced instruction is only accepted while running; it is single-cycle
  // and steals any coincident tick from the program instruction.
  assign grant      = exec_req & en & (state_q == SM_RUN);
  assign completion = (state_q == SM_RUN) & tick & ~instr_stall & ~grant;

  // Next-state, delay counter and PC-facing outputs.
  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    exec_ack     = grant;
    imm          = grant;
    delay_active = (state_q == SM_DELAY);
    stalled      = (state_q == SM_IDLE) | (state_q == SM_DELAY) |
                   ((state_q == SM_RUN) & instr_stall);

    if (restart) begin
      dcnt_d  = '0;
      state_d = en ? SM_RUN : SM_IDLE;
    end else if (!en) begin
      dcnt_d  = '0;
      state_d = SM_IDLE;
    end else begin
      case (state_q)
        SM_IDLE: begin
          state_d = SM_RUN;
        end
        SM_RUN: begin
          // Forced and program instructions share the same delay handling.
          if ((grant || completion) && (delay != '0)) begin
            dcnt_d  = delay;
            state_d = SM_DELAY;
          end
        end
        SM_DELAY: begin
          // The tick that finds dcnt at 1 is the last delay tick.
          if (tick) begin
            if (dcnt_q == DCNT_ONE) begin
              dcnt_d  = '0;
              state_d = SM_RUN;
            end else begin
              dcnt_d = dcnt_q - DCNT_ONE;
            end
          end
        end
        default: begin
          dcnt_d  = '0;
          state_d = SM_IDLE;
        end
      endcase
    end
  end

  // State and delay counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SM_IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign penable = tick;

endmodule
`default_nettype wire

// File: doc/pio_sm_sequencer.md
Name: pio_sm_sequencer

Overview:
Per-state-machine execution sequencer for a PIO block. It produces the fractional-divided execute strobe, handles instruction delay cycles and stalls, and grants forced-instruction (EXEC) injection. Its outputs drive the program counter's penable, stalled and imm inputs. One instance sits beside each state machine's PC and decoder.

Parameters:
DIV_INT_W, 16, integer part width of the clock divisor
DIV_FRAC_W, 8, fractional part width of the clock divisor
DELAY_W, 5, width of the instruction delay field

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  state machine enable (level)
restart  input  1  sync pulse: clear divider accumulator and delay counter
div_int  input  DIV_INT_W  divisor integer part; 0 means 2^DIV_INT_W
div_frac  input  DIV_FRAC_W  divisor fractional part
instr_stall  input  1  current instruction cannot complete this tick (WAIT, FIFO empty/full)
delay  input  DELAY_W  delay field of the instruction completing this cycle
exec_req  input  1  forced instruction presented (level, held until ack)
exec_ack  output  1  forced instruction accepted this cycle
penable  output  1  registered execute tick
stalled  output  1  hold PC this tick
imm  output  1  forced instruction executes this cycle
delay_active  output  1  sequencer in DELAY state

Behaviour:
- Reset (async) values: penable=0, exec_ack=0, imm=0, stalled=1, delay_active=0. State is IDLE, accumulator is 0, delay counter is 0.
- Divisor D = {div_int, div_frac} in 1/256 units. If div_int==0, D = 2^(DIV_INT_W+DIV_FRAC_W), which is also the floor against sub-unity divisors.
- Accumulator: width DIV_INT_W+DIV_FRAC_W+1. Each clk with en=1, compute s = acc + 2^DIV_FRAC_W.
  - If s >= D: acc <= s - D and penable <= 1.
  - Otherwise: acc <= s and penable <= 0.
- With en=0: penable <= 0 and acc is held.
- Divider examples: 1.0 ticks every cycle; 2.0 every second cycle; 1.5 gives pattern 0,1,1 repeating from the first enabled cycle.
- States: IDLE, RUN, DELAY.
  - IDLE: entered when en=0 (from any state; delay counter cleared). Moves to RUN on the first cycle with en=1.
  - RUN: a completion is a cycle with penable=1 and instr_stall=0. On completion, if delay!=0, load dcnt=delay and go to DELAY; otherwise stay in RUN. With penable=1 and instr_stall=1, stay in RUN and stall.
  - DELAY: on each penable, dcnt decrements. When dcnt==1 at a tick, go to RUN. A delay of N therefore consumes exactly N ticks.
- stalled (combinational) = (state==IDLE) | (state==DELAY) | (state==RUN & instr_stall).
- delay_active = (state==DELAY).
- Exec grant, combinational: imm = exec_ack = exec_req & en & (state==RUN).
  - Requests during DELAY or IDLE wait.
  - On a granted cycle, instr_stall is ignored; forced instructions are single-cycle by contract.
  - A nonzero delay on a granted cycle loads dcnt and enters DELAY, exactly as a program completion does.
  - If penable=1 in the same cycle as a grant, that tick is consumed by the forced instruction: no program completion occurs and the program instruction reissues on the next tick.
- restart: acc <= 0 and dcnt <= 0. State goes to RUN if en, otherwise IDLE. restart has priority over a coincident tick or completion; penable <= 0 that cycle.
- Divisor changes take effect on the next cycle; acc is not rescaled.
- Reset mid-DELAY: immediate return to reset values; no pending state survives.

Decomposition:
- Shared pio package holds:
  - the state enum (IDLE, RUN, DELAY)
  - DIV_INT_W / DIV_FRAC_W / DELAY_W defaults
  - the delay/side-set field split constants, shared with the decoder
- The fractional divider is a natural sub-module, pio_clkdiv (en, restart, div_int, div_frac -> penable). It is reused by future shared-clock modes.
- The FSM and exec grant stay in pio_sm_sequencer.

Test Plan:
- div=1.0, en=1, no stall -> penable=1 every cycle from the 2nd clk after en; stalled=0 throughout.
- div=1.5 -> penable sequence 0,1,1,0,1,1; div_int=0, frac=0 -> exactly one penable per 65536 cycles.
- div=1.0, completion with delay=3 -> delay_active=1 and stalled=1 for the next 3 ticks; the 4th tick has stalled=0 and delay_active=0.
- instr_stall=1 held for 5 ticks with delay=2 -> stalled=1 for those 5 ticks with no DELAY entry; on release, one completion, then 2 delay ticks.
- exec_req raised mid-DELAY (dcnt=2) -> exec_ack=0 until DELAY exits, then exec_ack=imm=1 for one cycle. A coincident tick produces no program completion. Exec with delay=2 -> DELAY for 2 ticks.
- reset asserted asynchronously mid-DELAY and mid-accumulation -> outputs at reset values immediately. After release with en=1, div=2.0 -> first penable on the 2nd enabled cycle.
